// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state, opcode, funct and select codes
package multicycle_control_pkg;

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_ADDIEX = 4'd8;
  localparam logic [3:0] ST_ADDIWB = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALU_MODE_NONE  = 2'd0,
    ALU_MODE_ADD   = 2'd1,
    ALU_MODE_SUB   = 2'd2,
    ALU_MODE_FUNCT = 2'd3
  } alu_mode_e;

  function automatic logic opcode_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - (funct, mode) to ALU control code
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct_i,
  input  alu_mode_e  mode_i,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_valid_o
);

  logic [3:0] funct_ctrl;

  always_comb begin
    funct_ctrl    = ALU_AND;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_ctrl = ALU_ADD;
      FN_SUB:  funct_ctrl = ALU_SUB;
      FN_AND:  funct_ctrl = ALU_AND;
      FN_OR:   funct_ctrl = ALU_OR;
      FN_SLT:  funct_ctrl = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl_o = 4'b0000;
    case (mode_i)
      ALU_MODE_ADD:   alu_ctrl_o = ALU_ADD;
      ALU_MODE_SUB:   alu_ctrl_o = ALU_SUB;
      ALU_MODE_FUNCT: alu_ctrl_o = funct_ctrl;
      default:        alu_ctrl_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       iorD,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [3:0] aluCtrl,
  output logic       illegalOp,
  output logic [3:0] state
);

  state_t    state_q, state_d;
  alu_mode_e alu_mode;
  logic      funct_valid;
  logic      pc_en_raw, ir_write_raw, reg_write_raw;
  logic      mem_read_raw, mem_write_raw, illegal_raw;

  alu_decoder u_alu_decoder (
    .funct_i       (funct),
    .mode_i        (alu_mode),
    .alu_ctrl_o    (aluCtrl),
    .funct_valid_o (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (memReady) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = ST_EXEC;
          OP_ADDI:        state_d = ST_ADDIEX;
          OP_LW, OP_SW:   state_d = ST_MEMADR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:           state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (memReady) state_d = ST_MEMWB;
      ST_MEMWR:  if (memReady) state_d = ST_FETCH;
      ST_EXEC:   state_d = funct_valid ? ST_ALUWB : ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    iorD          = 1'b0;
    regDst        = 1'b0;
    memToReg      = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_REG;
    pcSrc         = PCSRC_ALU;
    alu_mode      = ALU_MODE_NONE;
    case (state_q)
      ST_FETCH: begin
        mem_read_raw = 1'b1;
        aluSrcB      = SRCB_FOUR;
        alu_mode     = ALU_MODE_ADD;
        ir_write_raw = memReady;
        pc_en_raw    = memReady;
      end
      ST_DECODE: begin
        aluSrcB     = SRCB_IMM_SH;
        alu_mode    = ALU_MODE_ADD;
        illegal_raw = ~opcode_supported(opcode);
      end
      ST_MEMADR, ST_ADDIEX: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        alu_mode = ALU_MODE_ADD;
      end
      ST_MEMRD: begin
        mem_read_raw = 1'b1;
        iorD         = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_raw = 1'b1;
        memToReg      = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
      end
      ST_EXEC: begin
        aluSrcA     = 1'b1;
        alu_mode    = ALU_MODE_FUNCT;
        illegal_raw = ~funct_valid;
      end
      ST_ALUWB: begin
        reg_write_raw = 1'b1;
        regDst        = 1'b1;
      end
      ST_ADDIWB: reg_write_raw = 1'b1;
      ST_BRANCH: begin
        aluSrcA   = 1'b1;
        alu_mode  = ALU_MODE_SUB;
        pcSrc     = PCSRC_ALUOUT;
        pc_en_raw = (opcode == OP_BEQ) ? zero : ~zero;
      end
      ST_JUMP: begin
        pcSrc     = PCSRC_JUMP;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // FETCH decodes as a memory read, so strobes are masked while reset is held
  assign pcEn      = pc_en_raw & rst_n;
  assign irWrite   = ir_write_raw & rst_n;
  assign regWrite  = reg_write_raw & rst_n;
  assign memRead   = mem_read_raw & rst_n;
  assign memWrite  = mem_write_raw & rst_n;
  assign illegalOp = illegal_raw & rst_n;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized bench with instruction-level reference model
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, memReady;
  logic       pcEn, irWrite, regWrite, memRead, memWrite;
  logic       iorD, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [3:0] aluCtrl;
  logic       illegalOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .pcEn(pcEn), .irWrite(irWrite), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .iorD(iorD), .regDst(regDst),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
    .aluCtrl(aluCtrl), .illegalOp(illegalOp), .state(state)
  );

  typedef struct packed {
    logic       pcEn, irWrite, regWrite, memRead, memWrite;
    logic       iorD, regDst, memToReg, aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [3:0] aluCtrl;
    logic       illegalOp;
  } out_t;

  typedef struct {
    string name;
    int    got;
    int    exp;
  } lit_t;

  out_t got, e;
  assign got = {pcEn, irWrite, regWrite, memRead, memWrite, iorD, regDst, memToReg,
                aluSrcA, aluSrcB, pcSrc, aluCtrl, illegalOp};

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   m_state = 0;
  int   m_q[$];
  lit_t lits[$];
  lit_t l;

  int cap_cycles, cap_code, cap_rw, cap_rw_state, cap_rdst_state, cap_mw;
  int cap_ill, cap_ill_state, cap_mtr, cap_mtr_state, cap_alu_exec, cap_pcen_br, cap_pcsrc_br;

  function automatic bit op_ok(logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  function automatic bit fn_ok(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic logic [3:0] fn_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  // The instruction's path through the machine, before any wait repeats
  function automatic void load_steps(logic [5:0] op);
    m_q = {0, 1};
    case (op)
      6'h00:        m_q = {0, 1, 6, 7};
      6'h08:        m_q = {0, 1, 8, 9};
      6'h23:        m_q = {0, 1, 2, 3, 4};
      6'h2B:        m_q = {0, 1, 2, 5};
      6'h04, 6'h05: m_q = {0, 1, 10};
      6'h02:        m_q = {0, 1, 11};
      default:      m_q = {0, 1};
    endcase
  endfunction

  function automatic out_t exp_out(int s, logic rdy, logic z, logic [5:0] op, logic [5:0] fn);
    out_t o = '0;
    case (s)
      0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.aluCtrl = 4'b0010; o.irWrite = rdy; o.pcEn = rdy; end
      1:  begin o.aluSrcB = 2'b11; o.aluCtrl = 4'b0010; o.illegalOp = !op_ok(op); end
      2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluCtrl = 4'b0010; end
      3:  begin o.memRead = 1; o.iorD = 1; end
      4:  begin o.regWrite = 1; o.memToReg = 1; end
      5:  begin o.memWrite = 1; o.iorD = 1; end
      6:  begin o.aluSrcA = 1; o.aluCtrl = fn_alu(fn); o.illegalOp = !fn_ok(fn); end
      7:  begin o.regWrite = 1; o.regDst = 1; end
      8:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluCtrl = 4'b0010; end
      9:  o.regWrite = 1;
      10: begin o.aluSrcA = 1; o.aluCtrl = 4'b0110; o.pcSrc = 2'b01; o.pcEn = (op == 6'h04) ? z : !z; end
      11: begin o.pcSrc = 2'b10; o.pcEn = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic void expect_eq(string n, int g, int x);
    lits.push_back('{n, g, x});
  endfunction

  always @(negedge clk) begin
    while (lits.size() > 0) begin
      l = lits.pop_front();
      checks++;
      if (l.got != l.exp) begin
        errors++;
        $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", l.name, l.got, l.got, l.exp, l.exp);
      end
    end
    if (chk_en) begin
      e = exp_out(m_state, memReady, zero, opcode, funct);
      checks++;
      if (state !== m_state[3:0] || got !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t op=%h fn=%h: state %0d outs %b, expected state %0d outs %b",
                 $time, opcode, funct, state, got, m_state, e);
      end
      checks++;
      if ((memRead && memWrite) || (regWrite && memWrite)) begin
        errors++;
        $display("FAIL strobe_exclusive t=%0t: memRead=%b memWrite=%b regWrite=%b, expected no overlap",
                 $time, memRead, memWrite, regWrite);
      end
    end
  end

  task automatic drive_wait(inout int cnt);
    if (cnt < 0)      memReady = ($urandom_range(0, 3) != 0);
    else if (cnt > 0) begin memReady = 1'b0; cnt--; end
    else              memReady = 1'b1;
  endtask

  // zmode<0 randomizes zero each cycle; fw/mw<0 randomize memReady in wait states
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int fw, input int mw);
    int guard = 0;
    int fwl = fw;
    int mwl = mw;
    int s;
    opcode = op;
    funct  = fn;
    load_steps(op);
    cap_code = 0; cap_rw = 0; cap_rw_state = -1; cap_rdst_state = -1; cap_mw = 0;
    cap_ill = 0; cap_ill_state = -1; cap_mtr = 0; cap_mtr_state = -1;
    cap_alu_exec = -1; cap_pcen_br = -1; cap_pcsrc_br = -1;
    while (m_q.size() > 0 && guard < 64) begin
      s       = m_q[0];
      m_state = s;
      zero    = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      if (s == 0)               drive_wait(fwl);
      else if (s == 3 || s == 5) drive_wait(mwl);
      else                      memReady = 1'($urandom_range(0, 1));
      chk_en = 1'b1;
      @(negedge clk);
      cap_code = (cap_code << 4) | int'(state);
      if (regWrite) begin cap_rw++; cap_rw_state = int'(state); end
      if (regDst) cap_rdst_state = int'(state);
      if (memWrite) cap_mw++;
      if (illegalOp) begin cap_ill++; cap_ill_state = int'(state); end
      if (memToReg && regWrite) begin cap_mtr++; cap_mtr_state = int'(state); end
      if (state == 4'd6) cap_alu_exec = int'(aluCtrl);
      if (state == 4'd10) begin cap_pcen_br = int'(pcEn); cap_pcsrc_br = int'(pcSrc); end
      @(posedge clk);
      if ((s == 0 || s == 3 || s == 5) && !memReady) ;
      else if ((s == 1 && !op_ok(opcode)) || (s == 6 && !fn_ok(funct))) m_q.delete();
      else void'(m_q.pop_front());
      #1;
      guard++;
    end
    if (guard >= 64) expect_eq("instr_timeout", 1, 0);
    cap_cycles = guard;
  endtask

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    int k = int'($urandom_range(0, 7));
    case (k)
      0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h23; 3: op = 6'h2B;
      4: op = 6'h04; 5: op = 6'h05; 6: op = 6'h02;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op_ok(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    k = int'($urandom_range(0, 5));
    case (k)
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2A;
      default: begin
        fn = 6'($urandom_range(0, 63));
        while (fn_ok(fn)) fn = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  task automatic run_random(input int n);
    logic [5:0] op, fn;
    for (int i = 0; i < n; i++) begin
      pick(op, fn);
      run_instr(op, fn, -1, -1, -1);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; memReady = 1'b1;
    #3;
    expect_eq("reset_state", int'(state), 0);
    expect_eq("reset_strobes", int'({pcEn, irWrite, regWrite, memRead, memWrite, illegalOp}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0, 0);
    expect_eq("add_cycles", cap_cycles, 4);
    expect_eq("add_states", cap_code, 32'h0167);
    expect_eq("add_regwrite_cnt", cap_rw, 1);
    expect_eq("add_regwrite_state", cap_rw_state, 7);
    expect_eq("add_regdst_state", cap_rdst_state, 7);
    expect_eq("add_aluctrl_exec", cap_alu_exec, 2);

    run_instr(6'h23, 6'h00, 0, 0, 2);
    expect_eq("lw_cycles", cap_cycles, 7);
    expect_eq("lw_states", cap_code, 32'h0123334);
    expect_eq("lw_memtoreg_wb_cnt", cap_mtr, 1);
    expect_eq("lw_memtoreg_wb_state", cap_mtr_state, 4);

    run_instr(6'h04, 6'h00, 1, 0, 0);
    expect_eq("beq_cycles", cap_cycles, 3);
    expect_eq("beq_pcen", cap_pcen_br, 1);
    expect_eq("beq_pcsrc", cap_pcsrc_br, 1);
    run_instr(6'h05, 6'h00, 1, 0, 0);
    expect_eq("bne_pcen", cap_pcen_br, 0);

    run_instr(6'h3F, 6'h20, 0, 0, 0);
    expect_eq("illop_cycles", cap_cycles, 2);
    expect_eq("illop_pulses", cap_ill, 1);
    expect_eq("illop_state", cap_ill_state, 1);
    expect_eq("illop_writes", cap_rw + cap_mw, 0);

    run_instr(6'h00, 6'h07, 0, 0, 0);
    expect_eq("badfn_states", cap_code, 32'h016);
    expect_eq("badfn_illstate", cap_ill_state, 6);
    expect_eq("badfn_regwrite", cap_rw, 0);
    run_instr(6'h00, 6'h22, 0, 0, 0);
    expect_eq("after_badfn_states", cap_code, 32'h0167);

    run_instr(6'h2B, 6'h00, 0, 1, 0);
    expect_eq("sw_fetchwait_states", cap_code, 32'h00125);
    run_instr(6'h02, 6'h00, 0, 0, 0);
    expect_eq("j_cycles", cap_cycles, 3);

    run_random(300);

    chk_en = 1'b0;
    opcode = 6'h2B; funct = 6'h20; memReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0;
    @(negedge clk);
    expect_eq("memwr_state", int'(state), 5);
    expect_eq("memwr_strobe", int'(memWrite), 1);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("async_reset_state", int'(state), 0);
    expect_eq("async_reset_memwrite", int'(memWrite), 0);
    @(posedge clk);
    #1;
    expect_eq("held_reset_state", int'(state), 0);
    expect_eq("held_reset_strobes", int'({pcEn, irWrite, regWrite, memRead, memWrite, illegalOp}), 0);
    rst_n = 1'b1;

    run_instr(6'h23, 6'h00, 0, 0, 0);
    expect_eq("post_reset_lw_states", cap_code, 32'h01234);
    run_random(100);

    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
